// File: rtl/conv_inbuf_writer_if.sv
// ---------------------------------------------------------------------------
// conv_inbuf_writer_if
//   Bundles the control, input-stream and row-buffer write signals of
//   conv_inbuf_writer.
//
//   Handshake: a beat transfers on a rising clk edge where s_valid && s_ready.
//   The source holds s_pixels stable while s_valid is high and s_ready low.
//   The write side (wr_*) has no backpressure: every wr_en pulse is one write.
//
//   Modports:
//     master : frame source / controller (drives start, ix, iy, nif, s_*)
//     slave  : conv_inbuf_writer itself
//
//   Optional macro SLAB_WR_EN adds the 2-pixel slab write port
//   (slab_wr_en, slab_idx, slab_adr, slab_data).
//   dbg_state exposes the writer FSM state (0 IDLE, 1 LOAD, 2 DONE).
// ---------------------------------------------------------------------------
interface conv_inbuf_writer_if #(
  parameter int PIXELS_IN_ROW = 32,
  parameter int PIX_PER_BEAT  = 8,
  parameter int ADR_W         = 16
);
  logic                         start;
  logic [15:0]                  ix;
  logic [15:0]                  iy;
  logic [15:0]                  nif;
  logic [PIX_PER_BEAT*8-1:0]    s_pixels;
  logic                         s_valid;
  logic                         s_ready;
  logic                         wr_en;
  logic [1:0]                   wr_buf_idx;
  logic [ADR_W-1:0]             wr_adr;
  logic [PIXELS_IN_ROW*8-1:0]   wr_data;
  logic                         busy;
  logic                         done;
  logic [1:0]                   dbg_state;
`ifdef SLAB_WR_EN
  logic                         slab_wr_en;
  logic [1:0]                   slab_idx;
  logic [ADR_W-1:0]             slab_adr;
  logic [15:0]                  slab_data;

  modport master (
    output start, ix, iy, nif, s_pixels, s_valid,
    input  s_ready, wr_en, wr_buf_idx, wr_adr, wr_data, busy, done, dbg_state,
    input  slab_wr_en, slab_idx, slab_adr, slab_data
  );
  modport slave (
    input  start, ix, iy, nif, s_pixels, s_valid,
    output s_ready, wr_en, wr_buf_idx, wr_adr, wr_data, busy, done, dbg_state,
    output slab_wr_en, slab_idx, slab_adr, slab_data
  );
`else
  modport master (
    output start, ix, iy, nif, s_pixels, s_valid,
    input  s_ready, wr_en, wr_buf_idx, wr_adr, wr_data, busy, done, dbg_state
  );
  modport slave (
    input  start, ix, iy, nif, s_pixels, s_valid,
    output s_ready, wr_en, wr_buf_idx, wr_adr, wr_data, busy, done, dbg_state
  );
`endif
endinterface

// File: rtl/conv_inbuf_writer.sv
// ---------------------------------------------------------------------------
// conv_inbuf_writer
//   Fills the conv front-end row buffers from a row-major input stream
//   (row y, channel c, x). PIX_PER_BEAT-pixel beats are packed into
//   PIXELS_IN_ROW-pixel row words; row y goes to buffer (y mod BUFFERS_NUM)
//   at that buffer's next sequential address.
//
//   Ports:
//     clk    : clock, rising edge
//     reset  : synchronous, active-low
//     bus    : conv_inbuf_writer_if.slave
//              start/ix/iy/nif  frame start and geometry (sampled in IDLE)
//              s_pixels/s_valid/s_ready  input beat stream
//              wr_en/wr_buf_idx/wr_adr/wr_data  row-buffer write port
//              busy (LOAD), done (1-cycle end-of-frame pulse), dbg_state
//
//   Optional macro SLAB_WR_EN: adds the slab write port, which mirrors each
//   row write with the top two pixels of the word.
// ---------------------------------------------------------------------------
module conv_inbuf_writer #(
  parameter int PIXELS_IN_ROW = 32,
  parameter int PIX_PER_BEAT  = 8,
  parameter int BUFFERS_NUM   = 3,
  parameter int ADR_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  conv_inbuf_writer_if.slave bus
);
  localparam int BEAT_W = PIX_PER_BEAT * 8;
  localparam int WORD_W = PIXELS_IN_ROW * 8;
  localparam int BPW    = PIXELS_IN_ROW / PIX_PER_BEAT;  // beats per word
  localparam int WB_W   = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [15:0]       ix_q, ix_d;
  logic [15:0]       iy_q, iy_d;
  logic [15:0]       nif_q, nif_d;
  logic [15:0]       beat_last_q, beat_last_d;   // ceil(ix/PIX_PER_BEAT)-1
  logic [15:0]       beat_q, beat_d;             // beat within line
  logic [15:0]       chan_q, chan_d;
  logic [15:0]       row_q, row_d;
  logic [1:0]        buf_q, buf_d;               // row mod BUFFERS_NUM
  logic [WB_W-1:0]   wbeat_q, wbeat_d;           // beat slot within word
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADR_W-1:0]  adr_q [BUFFERS_NUM];
  logic [ADR_W-1:0]  adr_d [BUFFERS_NUM];

  logic              wr_en_q, wr_en_d;
  logic [1:0]        wr_buf_q, wr_buf_d;
  logic [ADR_W-1:0]  wr_adr_q, wr_adr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;

`ifdef SLAB_WR_EN
  logic              slab_en_q, slab_en_d;
  logic [1:0]        slab_idx_q, slab_idx_d;
  logic [ADR_W-1:0]  slab_adr_q, slab_adr_d;
  logic [15:0]       slab_data_q, slab_data_d;
`endif

  logic              beat_fire;
  logic              last_beat;
  logic              last_chan;
  logic              last_row;
  logic              commit;
  logic [31:0]       beat_x;       // x of pixel 0 of the current beat
  logic [31:0]       beats_line;
  logic [BEAT_W-1:0] beat_masked;
  logic [WORD_W-1:0] word_next;

  assign beat_fire = (state_q == ST_LOAD) && bus.s_valid;
  assign last_beat = (beat_q == beat_last_q);
  assign last_chan = (chan_q == nif_q - 16'd1);
  assign last_row  = (row_q == iy_q - 16'd1);
  assign commit    = beat_fire && ((wbeat_q == WB_W'(BPW - 1)) || last_beat);
  assign beat_x    = 32'(beat_q) * 32'(PIX_PER_BEAT);
  assign beats_line = (32'(bus.ix) + 32'(PIX_PER_BEAT - 1)) / 32'(PIX_PER_BEAT);

  // Pixels beyond the row width are forced to zero; unfilled beat slots are
  // already zero because word_q is cleared after each commit.
  always_comb begin
    beat_masked = '0;
    for (int i = 0; i < PIX_PER_BEAT; i++) begin
      if (beat_x + 32'(i) < 32'(ix_q)) begin
        beat_masked[i*8 +: 8] = bus.s_pixels[i*8 +: 8];
      end
    end
    word_next = word_q;
    word_next[32'(wbeat_q)*BEAT_W +: BEAT_W] = beat_masked;
  end

  always_comb begin
    state_d     = state_q;
    ix_d        = ix_q;
    iy_d        = iy_q;
    nif_d       = nif_q;
    beat_last_d = beat_last_q;
    beat_d      = beat_q;
    chan_d      = chan_q;
    row_d       = row_q;
    buf_d       = buf_q;
    wbeat_d     = wbeat_q;
    word_d      = word_q;
    adr_d       = adr_q;
    wr_en_d     = 1'b0;
    wr_buf_d    = wr_buf_q;
    wr_adr_d    = wr_adr_q;
    wr_data_d   = wr_data_q;
`ifdef SLAB_WR_EN
    slab_en_d   = 1'b0;
    slab_idx_d  = slab_idx_q;
    slab_adr_d  = slab_adr_q;
    slab_data_d = slab_data_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          ix_d        = bus.ix;
          iy_d        = bus.iy;
          nif_d       = bus.nif;
          beat_last_d = 16'(beats_line - 32'd1);
          beat_d      = '0;
          chan_d      = '0;
          row_d       = '0;
          buf_d       = '0;
          wbeat_d     = '0;
          word_d      = '0;
          for (int b = 0; b < BUFFERS_NUM; b++) adr_d[b] = '0;
          if (bus.ix == 16'd0 || bus.iy == 16'd0 || bus.nif == 16'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (beat_fire) begin
          beat_d  = beat_q + 16'd1;
          wbeat_d = wbeat_q + WB_W'(1);
          word_d  = word_next;
          if (commit) begin
            wr_en_d        = 1'b1;
            wr_buf_d       = buf_q;
            wr_adr_d       = adr_q[buf_q];
            wr_data_d      = word_next;
            adr_d[buf_q]   = adr_q[buf_q] + ADR_W'(1);
            wbeat_d        = '0;
            word_d         = '0;
`ifdef SLAB_WR_EN
            slab_en_d      = 1'b1;
            slab_idx_d     = buf_q;
            slab_adr_d     = adr_q[buf_q];
            slab_data_d    = word_next[WORD_W-1 -: 16];
`endif
          end
          if (last_beat) begin
            beat_d = '0;
            if (last_chan) begin
              chan_d = '0;
              if (last_row) begin
                state_d = ST_DONE;
              end else begin
                row_d = row_q + 16'd1;
                buf_d = (buf_q == 2'(BUFFERS_NUM - 1)) ? 2'd0 : buf_q + 2'd1;
              end
            end else begin
              chan_d = chan_q + 16'd1;
            end
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ix_q        <= '0;
      iy_q        <= '0;
      nif_q       <= '0;
      beat_last_q <= '0;
      beat_q      <= '0;
      chan_q      <= '0;
      row_q       <= '0;
      buf_q       <= '0;
      wbeat_q     <= '0;
      word_q      <= '0;
      for (int b = 0; b < BUFFERS_NUM; b++) adr_q[b] <= '0;
      wr_en_q     <= 1'b0;
      wr_buf_q    <= '0;
      wr_adr_q    <= '0;
      wr_data_q   <= '0;
`ifdef SLAB_WR_EN
      slab_en_q   <= 1'b0;
      slab_idx_q  <= '0;
      slab_adr_q  <= '0;
      slab_data_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ix_q        <= ix_d;
      iy_q        <= iy_d;
      nif_q       <= nif_d;
      beat_last_q <= beat_last_d;
      beat_q      <= beat_d;
      chan_q      <= chan_d;
      row_q       <= row_d;
      buf_q       <= buf_d;
      wbeat_q     <= wbeat_d;
      word_q      <= word_d;
      adr_q       <= adr_d;
      wr_en_q     <= wr_en_d;
      wr_buf_q    <= wr_buf_d;
      wr_adr_q    <= wr_adr_d;
      wr_data_q   <= wr_data_d;
`ifdef SLAB_WR_EN
      slab_en_q   <= slab_en_d;
      slab_idx_q  <= slab_idx_d;
      slab_adr_q  <= slab_adr_d;
      slab_data_q <= slab_data_d;
`endif
    end
  end

  // Ready stays high through write cycles: the write port never stalls.
  assign bus.s_ready    = (state_q == ST_LOAD);
  assign bus.busy       = (state_q == ST_LOAD);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.dbg_state  = state_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_buf_idx = wr_buf_q;
  assign bus.wr_adr     = wr_adr_q;
  assign bus.wr_data    = wr_data_q;
`ifdef SLAB_WR_EN
  assign bus.slab_wr_en = slab_en_q;
  assign bus.slab_idx   = slab_idx_q;
  assign bus.slab_adr   = slab_adr_q;
  assign bus.slab_data  = slab_data_q;
`endif

endmodule

// File: tb/tb_conv_inbuf_writer.sv
// ---------------------------------------------------------------------------
// tb_conv_inbuf_writer
//   Frame-level bench for conv_inbuf_writer. A table of frame geometries is
//   run through a beat driver; a pixel-level reference model fills the
//   expected write queue, and a negedge monitor compares every write (and the
//   held outputs between writes). Hand sequences cover reset mid-frame.
//   Honours SLAB_WR_EN when defined.
// ---------------------------------------------------------------------------
module tb_conv_inbuf_writer;
  localparam int P      = 32;
  localparam int PPB    = 8;
  localparam int ADR_W  = 16;
  localparam int WORD_W = P * 8;
  localparam int EXP_W  = 2 + ADR_W + WORD_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  conv_inbuf_writer_if #(.PIXELS_IN_ROW(P), .PIX_PER_BEAT(PPB), .ADR_W(ADR_W)) bus();

  conv_inbuf_writer #(
    .PIXELS_IN_ROW(P), .PIX_PER_BEAT(PPB), .BUFFERS_NUM(3), .ADR_W(ADR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int               checks   = 0;
  int               failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] last_exp = '0;
  int               wr_count = 0;
  int               done_count = 0;
  logic             done_with_wr = 1'b0;

  task automatic check(input string name, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int line, input int x);
    return 8'(seed * 7 + line * 29 + x * 3 + 1);
  endfunction

  // Monitor: every write is matched against the model; between writes the
  // write port must hold the last written values.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!reset) begin
      last_exp = '0;
    end else begin
      if (bus.done) begin
        done_count++;
        done_with_wr = bus.wr_en;
      end
      if (bus.wr_en) begin
        wr_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          last_exp = e;
          check("write", {bus.wr_buf_idx, bus.wr_adr, bus.wr_data}, e);
`ifdef SLAB_WR_EN
          check("slab_write", {bus.slab_wr_en, bus.slab_idx, bus.slab_adr, bus.slab_data},
                {1'b1, e[EXP_W-1 -: 2], e[WORD_W +: ADR_W], e[WORD_W-1 -: 16]});
`endif
        end
      end else begin
        check("hold", {bus.wr_buf_idx, bus.wr_adr, bus.wr_data}, last_exp);
`ifdef SLAB_WR_EN
        check("slab_idle", bus.slab_wr_en, 0);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int ix, input int iy, input int nif);
    @(posedge clk); #1;
    bus.ix    = 16'(ix);
    bus.iy    = 16'(iy);
    bus.nif   = 16'(nif);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_frame(input int ix, input int iy, input int nif, input bit tog,
                           input int exp_writes, input int seed);
    int bpl, wpl, total, b, cyc, ln, bb;
    int adr_cnt[3];
    bit v, phase, hs;
    logic [WORD_W-1:0] data;
    bpl   = (ix + PPB - 1) / PPB;
    wpl   = (ix + P - 1) / P;
    total = iy * nif * bpl;
    adr_cnt = '{0, 0, 0};
    // Reference model: pixel by pixel, zero beyond ix.
    for (int y = 0; y < iy; y++) begin
      for (int c = 0; c < nif; c++) begin
        for (int w = 0; w < wpl; w++) begin
          data = '0;
          for (int p = 0; p < P; p++) begin
            if (w * P + p < ix) data[p*8 +: 8] = pix(seed, y * nif + c, w * P + p);
          end
          exp_q.push_back({2'(y % 3), 16'(adr_cnt[y % 3]), data});
          adr_cnt[y % 3]++;
        end
      end
    end
    wr_count = 0;
    done_count = 0;
    done_with_wr = 1'b0;
    pulse_start(ix, iy, nif);
    b = 0; cyc = 0; phase = 1'b0;
    while (b < total && cyc < 4000) begin
      v = tog ? phase : 1'b1;
      phase = ~phase;
      ln = b / bpl;
      bb = b % bpl;
      for (int i = 0; i < PPB; i++) bus.s_pixels[i*8 +: 8] = pix(seed, ln, bb * PPB + i);
      bus.s_valid = v;
      // A start pulse during LOAD must be ignored.
      bus.start = tog && (b == 1);
      @(negedge clk);
      if (cyc == 0) check("busy_ready_in_load", {bus.busy, bus.s_ready}, 2'b11);
      hs = v && bus.s_ready;
      @(posedge clk); #1;
      if (hs) b++;
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.start   = 1'b0;
    if (b < total) check("beat_timeout", b, total);
    for (int k = 0; k < 10 && done_count == 0; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_count, 1);
    check("done_with_last_write", done_with_wr, (exp_writes > 0) ? 1 : 0);
    check("write_count", wr_count, exp_writes);
    check("writes_outstanding", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  typedef struct {
    int ix;
    int iy;
    int nif;
    bit tog;
    int exp_writes;
  } frame_vec_t;

  frame_vec_t vecs[9];

  initial begin
    bus.start    = 1'b0;
    bus.ix       = '0;
    bus.iy       = '0;
    bus.nif      = '0;
    bus.s_pixels = '0;
    bus.s_valid  = 1'b0;

    // Hand-computed: writes = iy * nif * ceil(ix/32).
    vecs[0] = '{ix: 32, iy: 3, nif: 1, tog: 1'b0, exp_writes: 3};
    vecs[1] = '{ix: 40, iy: 4, nif: 1, tog: 1'b0, exp_writes: 8};
    vecs[2] = '{ix: 36, iy: 1, nif: 2, tog: 1'b0, exp_writes: 4};
    vecs[3] = '{ix: 32, iy: 2, nif: 1, tog: 1'b1, exp_writes: 2};
    vecs[4] = '{ix: 8,  iy: 5, nif: 2, tog: 1'b1, exp_writes: 10};
    vecs[5] = '{ix: 70, iy: 2, nif: 3, tog: 1'b0, exp_writes: 18};
    vecs[6] = '{ix: 1,  iy: 4, nif: 1, tog: 1'b0, exp_writes: 4};
    vecs[7] = '{ix: 32, iy: 2, nif: 0, tog: 1'b0, exp_writes: 0};
    vecs[8] = '{ix: 0,  iy: 2, nif: 1, tog: 1'b0, exp_writes: 0};

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_ctrl", {bus.s_ready, bus.wr_en, bus.busy, bus.done, bus.dbg_state}, 0);
    check("reset_wr_bus", {bus.wr_buf_idx, bus.wr_adr, bus.wr_data}, 0);

    for (int n = 0; n < 9; n++) begin
      run_frame(vecs[n].ix, vecs[n].iy, vecs[n].nif, vecs[n].tog, vecs[n].exp_writes, n + 1);
    end

    // Reset mid-frame after two beats: the partial word must be discarded.
    pulse_start(32, 1, 1);
    bus.s_pixels = {8{8'hA5}};
    bus.s_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midframe_reset_ctrl", {bus.s_ready, bus.wr_en, bus.busy, bus.done, bus.dbg_state}, 0);
    check("midframe_reset_wr_bus", {bus.wr_buf_idx, bus.wr_adr, bus.wr_data}, 0);
    check("midframe_reset_no_write", wr_count, 0);
    run_frame(32, 1, 1, 1'b0, 1, 42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
